// File: rtl/fft_peak_bin_tracker.sv
// Tracks the strongest in-band FFT bin per frame and reports it as a
// one-cycle pulse with its squared magnitude and a voiced flag.
module fft_peak_bin_tracker #(
    parameter int          FFT_LEN    = 1024,
    parameter int          BIN_W      = $clog2(FFT_LEN),
    parameter int          MIN_BIN    = 2,
    parameter int          MAX_BIN    = FFT_LEN / 2 - 1,
    parameter logic [31:0] MAG_THRESH = 32'd4096
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             enable_in,
    input  logic             fft_valid_in,
    input  logic             fft_last_in,
    input  logic [31:0]      fft_data_in,
    output logic [BIN_W-1:0] peak_bin_out,
    output logic [31:0]      peak_mag_out,
    output logic             voiced_out,
    output logic             peak_valid_out,
    output logic             frame_error_out
);

    typedef enum logic [1:0] {IDLE, ACCUM, SKIP, REPORT} state_t;

    localparam logic [BIN_W-1:0] TOP_BIN = BIN_W'(FFT_LEN - 1);
    localparam logic [BIN_W-1:0] LO_BIN  = BIN_W'(MIN_BIN);
    localparam logic [BIN_W-1:0] HI_BIN  = BIN_W'(MAX_BIN);

    state_t state, next_state;

    logic [BIN_W-1:0] cnt;
    logic             frame_en;
    logic             is_top;
    logic             bad_beat;
    logic             beat_acc;

    logic signed [15:0] re;
    logic signed [15:0] im;
    logic signed [30:0] re_x;
    logic signed [30:0] im_x;
    logic signed [30:0] re_sq;
    logic signed [30:0] im_sq;

    logic             s1_valid, s1_last, s1_acc, s1_err;
    logic [BIN_W-1:0] s1_bin;
    logic [30:0]      s1_rr, s1_ii;

    logic             s2_valid, s2_last, s2_acc, s2_err;
    logic [BIN_W-1:0] s2_bin;
    logic [31:0]      s2_mag;

    logic [31:0]      max_mag;
    logic [BIN_W-1:0] max_bin;
    logic [31:0]      base_mag;
    logic [BIN_W-1:0] base_bin;
    logic             in_band;
    logic             take;

    assign is_top   = (cnt == TOP_BIN);
    assign bad_beat = fft_valid_in && (fft_last_in != is_top);
    // enable is only honoured on bin 0; later beats reuse the captured value
    assign beat_acc = (cnt == '0) ? enable_in : frame_en;

    assign re    = fft_data_in[15:0];
    assign im    = fft_data_in[31:16];
    assign re_x  = 31'(re);
    assign im_x  = 31'(im);
    assign re_sq = re_x * re_x;
    assign im_sq = im_x * im_x;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt      <= '0;
            frame_en <= 1'b0;
        end else if (fft_valid_in) begin
            if (bad_beat || is_top)
                cnt <= '0;
            else
                cnt <= cnt + BIN_W'(1);
            if (cnt == '0)
                frame_en <= enable_in;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_acc   <= 1'b0;
            s1_err   <= 1'b0;
            s1_bin   <= '0;
            s1_rr    <= '0;
            s1_ii    <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_acc   <= 1'b0;
            s2_err   <= 1'b0;
            s2_bin   <= '0;
            s2_mag   <= '0;
        end else begin
            s1_valid <= fft_valid_in;
            s1_last  <= fft_valid_in && fft_last_in && !bad_beat;
            s1_acc   <= fft_valid_in && beat_acc && !bad_beat;
            s1_err   <= bad_beat;
            s1_bin   <= cnt;
            s1_rr    <= re_sq;
            s1_ii    <= im_sq;
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_acc   <= s1_acc;
            s2_err   <= s1_err;
            s2_bin   <= s1_bin;
            s2_mag   <= {1'b0, s1_rr} + {1'b0, s1_ii};
        end
    end

    // bin 0 restarts the search so a report can overlap the next frame
    always_comb begin
        base_mag = max_mag;
        base_bin = max_bin;
        if (s2_bin == '0) begin
            base_mag = '0;
            base_bin = LO_BIN;
        end
        in_band = (s2_bin >= LO_BIN) && (s2_bin <= HI_BIN);
        take    = s2_valid && s2_acc && in_band && (s2_mag > base_mag);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            max_mag <= '0;
            max_bin <= '0;
        end else if (s2_valid && s2_acc) begin
            max_mag <= take ? s2_mag : base_mag;
            max_bin <= take ? s2_bin : base_bin;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (s2_valid && !s2_err)
                    next_state = s2_acc ? ACCUM : SKIP;
            end
            ACCUM: begin
                if (s2_err)
                    next_state = IDLE;
                else if (s2_valid && s2_last)
                    next_state = REPORT;
            end
            SKIP: begin
                if (s2_err || (s2_valid && s2_last))
                    next_state = IDLE;
            end
            REPORT: begin
                if (s2_valid && !s2_err)
                    next_state = s2_acc ? ACCUM : SKIP;
                else
                    next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            peak_bin_out    <= '0;
            peak_mag_out    <= '0;
            voiced_out      <= 1'b0;
            peak_valid_out  <= 1'b0;
            frame_error_out <= 1'b0;
        end else begin
            peak_valid_out  <= (state == REPORT);
            frame_error_out <= bad_beat;
            if (state == REPORT) begin
                peak_bin_out <= max_bin;
                peak_mag_out <= max_mag;
                voiced_out   <= (max_mag >= MAG_THRESH);
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_bin_tracker.sv
// Scoreboard bench: frames are driven with a per-frame peak model; reports
// are popped and compared as the tracker emits them.
module tb_fft_peak_bin_tracker;

    localparam int N    = 16;
    localparam int MINB = 2;
    localparam int MAXB = N / 2 - 1;

    logic        clk_in       = 1'b0;
    logic        rst_in       = 1'b1;
    logic        enable_in    = 1'b0;
    logic        fft_valid_in = 1'b0;
    logic        fft_last_in  = 1'b0;
    logic [31:0] fft_data_in  = '0;
    logic [3:0]  peak_bin_out;
    logic [31:0] peak_mag_out;
    logic        voiced_out;
    logic        peak_valid_out;
    logic        frame_error_out;

    typedef struct {
        int     bin;
        longint mag;
        int     voiced;
        int     cyc;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   vcount = 0;
    int   ecount = 0;
    exp_t sb[$];
    exp_t mon_e;
    int   fr_re[N];
    int   fr_im[N];

    fft_peak_bin_tracker #(.FFT_LEN(N)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .enable_in      (enable_in),
        .fft_valid_in   (fft_valid_in),
        .fft_last_in    (fft_last_in),
        .fft_data_in    (fft_data_in),
        .peak_bin_out   (peak_bin_out),
        .peak_mag_out   (peak_mag_out),
        .voiced_out     (voiced_out),
        .peak_valid_out (peak_valid_out),
        .frame_error_out(frame_error_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (peak_valid_out) begin
                vcount++;
                if (sb.size() == 0) begin
                    check("spurious_valid", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("bin", 64'(peak_bin_out), 64'(mon_e.bin));
                    check("mag", 64'(peak_mag_out), 64'(mon_e.mag));
                    check("voiced", 64'(voiced_out), 64'(mon_e.voiced));
                    check("latency", 64'(cyc - mon_e.cyc), 64'd3);
                end
            end
            if (frame_error_out)
                ecount++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic clear_frame();
        for (int i = 0; i < N; i++) begin
            fr_re[i] = 0;
            fr_im[i] = 0;
        end
    endtask

    task automatic send_frame(input logic en0, input logic en_rest,
                              input int last_at, input bit drop_last,
                              input int gap);
        exp_t   e;
        longint m;
        longint best;
        int     bb;
        best = 0;
        bb   = MINB;
        for (int b = MINB; b <= MAXB; b++) begin
            m = longint'(fr_re[b]) * fr_re[b] + longint'(fr_im[b]) * fr_im[b];
            if (m > best) begin
                best = m;
                bb   = b;
            end
        end
        for (int b = 0; b <= last_at; b++) begin
            if (gap > 0 && b % gap == 1) begin
                fft_valid_in = 1'b0;
                fft_last_in  = 1'b1;
                fft_data_in  = 32'h7fff_7fff;
                enable_in    = ~en0;
                @(posedge clk_in);
                #1;
            end
            fft_valid_in = 1'b1;
            fft_last_in  = (b == last_at) && !drop_last;
            enable_in    = (b == 0) ? en0 : en_rest;
            fft_data_in  = {fr_im[b][15:0], fr_re[b][15:0]};
            @(posedge clk_in);
            #1;
            if (b == last_at && last_at == N - 1 && !drop_last && en0) begin
                e.bin    = bb;
                e.mag    = best;
                e.voiced = int'(best >= 4096);
                e.cyc    = cyc;
                sb.push_back(e);
            end
        end
        fft_valid_in = 1'b0;
        fft_last_in  = 1'b0;
    endtask

    initial begin
        int t;
        clear_frame();
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_bin", 64'(peak_bin_out), 0);
        check("rst_mag", 64'(peak_mag_out), 0);
        check("rst_voiced", 64'(voiced_out), 0);
        check("rst_valid", 64'(peak_valid_out), 0);
        check("rst_err", 64'(frame_error_out), 0);
        rst_in = 1'b0;
        idle(2);

        clear_frame();
        fr_re[5] = 1000;
        send_frame(1, 1, N - 1, 0, 0);
        idle(6);

        clear_frame();
        fr_re[3] = 300;
        fr_im[6] = 300;
        fr_re[1] = 20000;
        send_frame(1, 1, N - 1, 0, 0);
        idle(6);

        clear_frame();
        fr_re[4] = 50;
        send_frame(1, 1, N - 1, 0, 0);
        idle(6);

        clear_frame();
        fr_re[7] = -32768;
        fr_im[7] = -32768;
        send_frame(1, 1, N - 1, 0, 0);
        idle(6);

        clear_frame();
        fr_re[5] = 999;
        send_frame(1, 1, 9, 0, 0);
        idle(6);
        check("err_short_last", 64'(ecount), 1);

        clear_frame();
        fr_re[6] = -700;
        fr_im[6] = 300;
        send_frame(1, 1, N - 1, 0, 0);
        idle(6);

        clear_frame();
        fr_re[3] = 800;
        send_frame(1, 1, N - 1, 1, 0);
        idle(6);
        check("err_missing_last", 64'(ecount), 2);

        clear_frame();
        fr_re[4] = 2000;
        send_frame(0, 1, N - 1, 0, 0);
        idle(6);
        check("skip_no_pulse", 64'(vcount), 5);

        clear_frame();
        send_frame(1, 1, N - 1, 0, 0);
        idle(6);

        clear_frame();
        fr_re[7] = 400;
        fr_re[8] = 30000;
        send_frame(1, 1, N - 1, 0, 3);
        clear_frame();
        fr_re[2] = 100;
        fr_im[9] = 5000;
        send_frame(1, 1, N - 1, 0, 2);
        clear_frame();
        fr_re[3] = 1234;
        send_frame(1, 1, 5, 1, 0);
        #2;
        rst_in = 1'b1;
        #1;
        check("async_rst_bin", 64'(peak_bin_out), 0);
        check("async_rst_mag", 64'(peak_mag_out), 0);
        check("async_rst_voiced", 64'(voiced_out), 0);
        idle(2);
        rst_in = 1'b0;
        idle(8);
        check("rst_no_pulse", 64'(vcount), 8);

        clear_frame();
        fr_re[4] = 100;
        send_frame(1, 1, N - 1, 0, 0);

        t = 0;
        while (sb.size() > 0 && t < 50) begin
            idle(1);
            t++;
        end
        idle(2);
        check("drain", 64'(sb.size()), 0);
        check("total_valid", 64'(vcount), 9);
        check("total_err", 64'(ecount), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_peak_bin_tracker.md
Name: fft_peak_bin_tracker

Overview:
Sits between the FFT core output stream and tone_detection_fsm.
- Per FFT frame: computes |X|² for each bin and tracks the strongest bin within a configured band.
- Emits one dominant-bin index per frame as a single-cycle valid pulse.
- The index, zero-extended to 32 bits, is the frequency word the tone detector captures each frame.

Parameters:
FFT_LEN, 1024, bins per frame (power of two).
BIN_W, $clog2(FFT_LEN), bin index width.
MIN_BIN, 2, lowest bin searched; excludes DC/near-DC.
MAX_BIN, FFT_LEN/2-1, highest bin searched; excludes mirrored half.
MAG_THRESH, 32'd4096, minimum peak |X|² for a frame to count as voiced.

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous active-high reset
enable_in  input  1  external recording-active qualifier, sampled at frame start
fft_valid_in  input  1  FFT output beat valid (no backpressure)
fft_last_in  input  1  marks final beat of frame
fft_data_in  input  32  signed {im[31:16], re[15:0]}
peak_bin_out  output  BIN_W  dominant bin of last completed frame
peak_mag_out  output  32  |X|² of that bin
voiced_out  output  1  peak_mag_out >= MAG_THRESH
peak_valid_out  output  1  one-cycle pulse: new result on the three outputs above
frame_error_out  output  1  one-cycle pulse: malformed frame discarded

Behaviour:
Clock and reset
- One clock: clk_in.
- Reset rst_in is asynchronous, active-high.
- Reset values: all outputs 0, state IDLE, counters 0, running max 0.
- Reset mid-frame drops that frame and produces no output pulse.

Magnitude pipeline
- Stage 1 registers re*re and im*im, each signed 16x16 giving an unsigned 31-bit result.
- Stage 2 registers mag = sum, 32-bit unsigned; cannot overflow (max 2^31).
- Stage 2 also carries the bin index and the last flag alongside mag.

Bin counter
- Increments on each accepted beat; bin of beat = counter value before increment.

FSM
- IDLE: on fft_valid_in:
  - if enable_in=1: go to ACCUM, clear max.
  - else: go to SKIP.
  - This first beat is bin 0 either way.
- ACCUM: compare stage-2 mag for bins MIN_BIN..MAX_BIN only.
  - Update when mag > max (strict), so ties keep the lowest bin.
  - Go to REPORT when the stage-2 last flag is seen.
- SKIP: count beats with no compare. On last, return to IDLE with no pulse.
- REPORT: one cycle.
  - Load peak_bin_out, peak_mag_out, voiced_out.
  - Pulse peak_valid_out.
  - Go to IDLE.
- Latency: peak_valid_out asserts exactly 3 cycles after the clock edge accepting the last beat.

Outputs
- peak_bin_out, peak_mag_out and voiced_out hold until the next REPORT.
- If no in-band bin ever exceeds 0 (all-zero frame): peak_bin_out = MIN_BIN, peak_mag_out = 0, voiced_out = 0.

Frame errors (both reset the counter to 0, then IDLE, no peak_valid_out)
- fft_last_in on a beat whose bin != FFT_LEN-1: frame_error_out pulses one cycle.
- Beat at bin FFT_LEN-1 without fft_last_in: frame_error_out pulses one cycle.

Other rules
- enable_in changes mid-frame are ignored; only the value at bin 0 matters.
- Beats with fft_valid_in=0 are bubbles: no count, no compare; the pipeline still advances.
- Back-to-back frames (bin 0 of the next frame on the cycle after last) are accepted with no lost beat.
  - The REPORT of frame N overlaps accumulation of frame N+1, so the max is cleared via the stage-2 bin==0 flag, not on the state transition.

Test Plan:
1. FFT_LEN=16, enable=1, single tone: re=1000 at bin 5, all others 0 -> 3 cycles after last: peak_valid_out=1, peak_bin_out=5, peak_mag_out=1000000, voiced_out=1.
2. Equal magnitude 300² at bins 3 and 6, others 0 -> peak_bin_out=3, peak_mag_out=90000, voiced_out=1. Bin 1 at 20000 -> ignored (below MIN_BIN).
3. Peak re=50 at bin 4 -> peak_mag_out=2500, voiced_out=0. Full-scale re=-32768, im=-32768 -> peak_mag_out=2^31, no overflow.
4. fft_last_in at bin 9 of 16 -> frame_error_out pulse, no peak_valid_out. The next well-formed frame reports normally.
5. enable_in=0 at bin 0, then 1 mid-frame -> frame skipped, no pulses. Next frame with enable=1 reports.
6. Two back-to-back frames, peaks at bin 7 then bin 2 with bubbles inserted -> two pulses giving 7 then 2. rst_in asserted mid-third-frame -> outputs 0 immediately (async), no pulse.
